npu_out_collector: RTL and testbench

- Sits directly downstream of npu_simple. Consumes its 8-channel pooled output bus (out / out_en) with no backpressure.
- Reorders the tile-major, row-then-column output stream into a column-major output feature map memory (address = col*OUT_H + row), matching the input fmap layout.
- Exposes a 1-cycle-latency host read port and frame done/error status.
- Replaces the behavioural save logic of the bench with synthesizable RTL.

---
 rtl/npu_out_collector.sv | 115 +++++++++++
 tb/tb_npu_out_collector.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/npu_out_collector.sv
// npu_out_collector: reorders npu_simple tile-major pooled beats into a column-major fmap memory with a host read port
module npu_out_collector #(
  parameter int OUT_W     = 64,
  parameter int OUT_H     = 64,
  parameter int TILE_COLS = 34,
  parameter int CH        = 8,
  parameter int ADDR_B    = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [8*CH-1:0]   in_data,
  input  logic [CH-1:0]     in_valid,
  input  logic              rd_en,
  input  logic [ADDR_B-1:0] rd_addr,
  output logic [8*CH-1:0]   rd_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_B:0]   beat_cnt,
  output logic              err_overrun,
  output logic              err_mask
);
  localparam int AW        = ADDR_B + 1;
  localparam int TOTAL     = OUT_W * OUT_H;
  localparam int NT        = (OUT_W + TILE_COLS - 1) / TILE_COLS;
  localparam int LAST_COLS = (OUT_W % TILE_COLS == 0) ? TILE_COLS : OUT_W % TILE_COLS;
  localparam logic [AW-1:0] TILE_STEP = AW'(TILE_COLS * OUT_H);

  typedef enum logic [1:0] {S_IDLE, S_CAP, S_DONE} state_t;
  state_t state_q, state_d;

  logic [AW-1:0] c_q, c_d, r_q, r_d, t_q, t_d;
  logic [AW-1:0] base_q, base_d, addr_q, addr_d, cnt_q, cnt_d;
  logic          ovr_q, msk_q;
  logic [8*CH-1:0] rd_q;
  logic [8*CH-1:0] mem [TOTAL];
  logic          wr, c_wrap, r_wrap;
  logic [AW-1:0] tc;

  // a beat coinciding with start is dropped so the restarted frame begins clean
  assign wr     = state_q == S_CAP && in_valid[CH-1] && !start;
  assign tc     = AW'(t_q == AW'(NT - 1) ? LAST_COLS : TILE_COLS);
  assign c_wrap = c_q == tc - 1'b1;
  assign r_wrap = r_q == AW'(OUT_H - 1);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb state_d = start ? S_CAP : (wr && cnt_q == AW'(TOTAL - 1)) ? S_DONE : state_q;

  always_comb begin
    busy = state_q == S_CAP;
    done = state_q == S_DONE;
  end

  // address tracked incrementally: +OUT_H per column, base+row on row wrap, next tile base on tile wrap
  always_comb begin
    c_d    = c_q;
    r_d    = r_q;
    t_d    = t_q;
    base_d = base_q;
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (start) begin
      c_d    = '0;
      r_d    = '0;
      t_d    = '0;
      base_d = '0;
      addr_d = '0;
      cnt_d  = '0;
    end else if (wr) begin
      cnt_d  = cnt_q + 1'b1;
      c_d    = c_wrap ? '0 : c_q + 1'b1;
      r_d    = !c_wrap ? r_q : r_wrap ? '0 : r_q + 1'b1;
      t_d    = (c_wrap && r_wrap) ? t_q + 1'b1 : t_q;
      base_d = (c_wrap && r_wrap) ? base_q + TILE_STEP : base_q;
      addr_d = !c_wrap ? addr_q + AW'(OUT_H) : r_wrap ? base_q + TILE_STEP : base_q + r_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q    <= '0;
      r_q    <= '0;
      t_q    <= '0;
      base_q <= '0;
      addr_q <= '0;
      cnt_q  <= '0;
      ovr_q  <= 1'b0;
      msk_q  <= 1'b0;
      rd_q   <= '0;
    end else begin
      c_q    <= c_d;
      r_q    <= r_d;
      t_q    <= t_d;
      base_q <= base_d;
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      ovr_q  <= ovr_q | (in_valid[CH-1] && state_q != S_CAP);
      msk_q  <= msk_q | (|in_valid && !(&in_valid));
      if (rd_en) rd_q <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (wr && !addr_q[ADDR_B]) mem[addr_q[ADDR_B-1:0]] <= in_data;
  end

  assign beat_cnt    = cnt_q;
  assign err_overrun = ovr_q;
  assign err_mask    = msk_q;
  assign rd_data     = rd_q;
endmodule

// File: tb/tb_npu_out_collector.sv
// tb_npu_out_collector: directed checks of frame capture, reorder, restart, errors and read port
module tb_npu_out_collector;
  logic        clk = 1'b0;
  logic        reset, start, rd_en;
  logic [63:0] in_data, rd_data;
  logic [7:0]  in_valid;
  logic [11:0] rd_addr;
  logic        busy, done, err_overrun, err_mask;
  logic [12:0] beat_cnt;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  model [4096];

  always #5 clk = ~clk;

  npu_out_collector dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data), .in_valid(in_valid),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .beat_cnt(beat_cnt), .err_overrun(err_overrun), .err_mask(err_mask)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a);
    rd_addr = a;
    rd_en   = 1'b1;
    tick;
    rd_en   = 1'b0;
  endtask

  function automatic logic [11:0] beat_addr(input int i);
    int t, w, tc;
    t  = i / 2176;
    w  = i % 2176;
    tc = (t == 0) ? 34 : 30;
    return 12'((t * 34 + w % tc) * 64 + w / tc);
  endfunction

  task automatic image(input string tag, input logic [7:0] x);
    int bad = 0;
    for (int a = 0; a < 4096; a++) begin
      rd(12'(a));
      if (rd_data !== {8{model[a] ^ x}}) bad++;
    end
    chk(tag, 64'(bad), 64'd0);
  endtask

  initial begin
    int sent, cyc;
    bit v;
    for (int i = 0; i < 4096; i++) model[beat_addr(i)] = 8'(i);
    reset = 1'b1; start = 1'b0; in_valid = '0; in_data = '0; rd_en = 1'b0; rd_addr = '0;
    tick; tick;
    reset = 1'b0;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_cnt", beat_cnt, 13'd0);
    chk("rst_ovr", err_overrun, 1'b0);
    chk("rst_msk", err_mask, 1'b0);
    chk("rst_rd", rd_data, 64'd0);

    start = 1'b1; tick; start = 1'b0;
    chk("start_busy", busy, 1'b1);
    for (int i = 0; i < 4096; i++) begin
      in_valid = 8'hFF;
      in_data  = {8{8'(i)}};
      tick;
      if (i == 4094) begin
        chk("pre_done", done, 1'b0);
        chk("pre_cnt", beat_cnt, 13'd4095);
      end
    end
    in_valid = '0;
    chk("full_done", done, 1'b1);
    chk("full_busy", busy, 1'b0);
    chk("full_cnt", beat_cnt, 13'd4096);
    rd(12'd0);    chk("rd_a0", rd_data, {8{8'h00}});
    rd(12'd2112); chk("rd_a2112", rd_data, {8{8'h21}});
    rd(12'd1);    chk("rd_a1", rd_data, {8{8'h22}});
    rd(12'd2176); chk("rd_a2176", rd_data, {8{8'h80}});
    rd(12'd4095); chk("rd_a4095", rd_data, {8{8'hFF}});
    rd_addr = 12'd0; tick;
    chk("rd_hold", rd_data, {8{8'hFF}});
    image("full_image", 8'h00);

    in_valid = 8'hFF; in_data = {8{8'hAA}}; tick; in_valid = '0; tick;
    chk("done_ovr", err_overrun, 1'b1);
    chk("done_ovr_cnt", beat_cnt, 13'd4096);
    chk("done_ovr_done", done, 1'b1);
    chk("done_ovr_msk", err_mask, 1'b0);
    rd(12'd0); chk("done_ovr_mem", rd_data, {8{8'h00}});

    start = 1'b1; tick; start = 1'b0;
    chk("gap_start_cnt", beat_cnt, 13'd0);
    sent = 0; cyc = 0;
    while (sent < 4096 && cyc < 20000) begin
      v        = (sent == 33) ? 1'b1 : 1'($urandom_range(0, 1));
      in_valid = v ? 8'hFF : 8'h00;
      in_data  = {8{~8'(sent)}};
      rd_en    = (sent == 33);
      rd_addr  = 12'd2112;
      tick;
      rd_en = 1'b0;
      if (sent == 33) chk("read_first", rd_data, {8{8'h21}});
      if (v) sent++;
      cyc++;
      if (v && sent == 1000) chk("gap_cnt", beat_cnt, 13'd1000);
    end
    in_valid = '0;
    chk("gap_done", done, 1'b1);
    chk("gap_cnt_end", beat_cnt, 13'd4096);
    rd(12'd2112); chk("gap_rd2112", rd_data, {8{8'hDE}});
    image("gap_image", 8'hFF);

    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      in_valid = 8'hFF;
      in_data  = {8{8'h5A}};
      tick;
    end
    chk("rs_cnt100", beat_cnt, 13'd100);
    start = 1'b1; in_data = {8{8'h77}}; tick; start = 1'b0;
    chk("rs_cnt0", beat_cnt, 13'd0);
    chk("rs_busy", busy, 1'b1);
    in_data = {8{8'h3C}}; tick;
    chk("rs_cnt1", beat_cnt, 13'd1);
    in_valid = 8'h80; in_data = {8{8'h11}}; tick;
    chk("msk80_err", err_mask, 1'b1);
    chk("msk80_cnt", beat_cnt, 13'd2);
    in_valid = 8'h7F; in_data = {8{8'h22}}; tick; in_valid = '0;
    chk("msk7f_cnt", beat_cnt, 13'd2);
    rd(12'd0);    chk("rs_a0", rd_data, {8{8'h3C}});
    rd(12'd64);   chk("msk80_mem", rd_data, {8{8'h11}});
    rd(12'd128);  chk("msk7f_mem", rd_data, {8{8'h5A}});
    rd(12'd2050); chk("rs_discard", rd_data, {8{8'h9B}});

    reset = 1'b1; tick; reset = 1'b0;
    chk("mid_busy", busy, 1'b0);
    chk("mid_done", done, 1'b0);
    chk("mid_cnt", beat_cnt, 13'd0);
    chk("mid_ovr", err_overrun, 1'b0);
    chk("mid_msk", err_mask, 1'b0);
    chk("mid_rd", rd_data, 64'd0);
    rd(12'd0); chk("mid_mem", rd_data, {8{8'h3C}});

    in_valid = 8'hFF; in_data = {8{8'hEE}}; tick; in_valid = '0;
    chk("idle_ovr", err_overrun, 1'b1);
    chk("idle_busy", busy, 1'b0);
    chk("idle_cnt", beat_cnt, 13'd0);
    chk("idle_msk", err_mask, 1'b0);
    rd(12'd0); chk("idle_mem", rd_data, {8{8'h3C}});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
